// File: rtl/inbuf_offset_cal.sv
// -----------------------------------------------------------------------------
// inbuf_offset_cal
//
// Calibrates the input offset of a bank of input buffers, one lane at a time.
// For each lane the 4-bit trim code is swept from most negative to most
// positive. At each code the buffer output is held for SETTLE cycles and then
// sampled for SAMPLES cycles. The first code whose majority of samples is high
// is latched. When every lane is done, the calibrated codes stay applied and
// all buffers return to normal (pad) mode.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous reset, active high
//   start    in   one-cycle request to run calibration (ignored while busy)
//   inbuf_o  in   [NLANES]   buffer outputs, asynchronous to clk
//   osc      out  [4*NLANES] trim code per lane; lane i uses [4i+3:4i]
//                 bit 3 = sign (1 = positive), bits 2:0 = magnitude
//   osc_en   out  [NLANES]   calibration-mode enable, at most one bit high
//   busy     out  calibration in progress
//   done     out  one-cycle pulse at the end of a run
//   err      out  [NLANES]   per-lane failure (stuck high or stuck low)
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for start
// S_APPLY  | trim code k driven on the current lane, waiting SETTLE cycles
// S_SAMPLE | accumulating synchronized buffer output for SAMPLES cycles
// S_DECIDE | majority vote; trip, advance k, or flag the lane as failed
// S_NEXT   | lane finished, calibration enable dropped, pick next lane
// S_DONE   | one-cycle completion pulse

module inbuf_offset_cal #(
  parameter int NLANES  = 8,
  parameter int SETTLE  = 16,
  parameter int SAMPLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NLANES-1:0]     inbuf_o,
  output logic [4*NLANES-1:0]   osc,
  output logic [NLANES-1:0]     osc_en,
  output logic                  busy,
  output logic                  done,
  output logic [NLANES-1:0]     err
);

  localparam int LW   = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int OW   = $clog2(SAMPLES) + 1;
  localparam int TMAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE - 1);
  localparam logic [TW-1:0] T_SAMPLE = TW'(SAMPLES - 1);
  localparam logic [OW-1:0] HALF     = OW'(SAMPLES / 2);
  localparam logic [LW-1:0] LAST     = LW'(NLANES - 1);
  localparam logic [3:0]    K_LAST   = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DECIDE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state;
  logic [LW-1:0]     lane;
  logic [3:0]        k;
  logic [TW-1:0]     timer;
  logic [OW-1:0]     ones;
  logic [NLANES-1:0] sync1;
  logic [NLANES-1:0] sync2;

  logic              high;
  logic              enter_apply;
  logic [LW-1:0]     apply_lane;
  logic [3:0]        apply_k;
  logic [3:0]        apply_code;

  // Code index k = 0..14 is the signed value k-7 in sign-magnitude form.
  // Negative values carry a 0 sign bit, zero and positive values a 1.
  function automatic logic [3:0] enc(input logic [3:0] kk);
    logic [3:0] d;
    if (kk < 4'd7) begin
      d = 4'd7 - kk;
      return {1'b0, d[2:0]};
    end
    d = kk - 4'd7;
    return {1'b1, d[2:0]};
  endfunction

  // Two-flop synchronizer on every buffer output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= inbuf_o;
      sync2 <= sync1;
    end
  end

  // Every path into S_APPLY goes through one place so that the trim code and
  // enable outputs are only ever loaded together.
  always_comb begin
    high        = (ones > HALF);
    enter_apply = 1'b0;
    apply_lane  = lane;
    apply_k     = k;
    case (state)
      S_IDLE: begin
        enter_apply = start;
        apply_lane  = '0;
        apply_k     = '0;
      end
      S_DECIDE: begin
        // An exact tie is not a majority, so the sweep continues.
        enter_apply = !high && (k != K_LAST);
        apply_k     = k + 4'd1;
      end
      S_NEXT: begin
        enter_apply = (lane != LAST);
        apply_lane  = lane + 1'b1;
        apply_k     = '0;
      end
      default: ;
    endcase
  end

  assign apply_code = enc(apply_k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      lane   <= '0;
      k      <= '0;
      timer  <= '0;
      ones   <= '0;
      osc    <= {NLANES{4'b1000}};
      osc_en <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= '0;
    end else begin
      done <= 1'b0;

      if (enter_apply) begin
        // Only the lane under calibration gets a new code; the others keep
        // whatever they held, calibrated or not.
        for (int i = 0; i < NLANES; i++) begin
          osc_en[i] <= (LW'(i) == apply_lane);
          if (LW'(i) == apply_lane) begin
            osc[4*i +: 4] <= apply_code;
          end
        end
        lane  <= apply_lane;
        k     <= apply_k;
        timer <= T_SETTLE;
        ones  <= '0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            err   <= '0;
            busy  <= 1'b1;
            state <= S_APPLY;
          end
        end

        S_APPLY: begin
          if (timer == '0) begin
            timer <= T_SAMPLE;
            state <= S_SAMPLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_SAMPLE: begin
          ones <= ones + {{(OW-1){1'b0}}, sync2[lane]};
          if (timer == '0) begin
            state <= S_DECIDE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_DECIDE: begin
          if (enter_apply) begin
            state <= S_APPLY;
          end else begin
            // Reaching here means either a trip or the end of the sweep.
            // A trip at the very first code means the buffer never read low;
            // no trip at the last code means it never read high. In both
            // cases the code already applied is the one that is kept.
            osc_en <= '0;
            state  <= S_NEXT;
            if (!high || (k == '0)) begin
              err[lane] <= 1'b1;
            end
          end
        end

        S_NEXT: begin
          if (enter_apply) begin
            state <= S_APPLY;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inbuf_offset_cal.sv
module tb_inbuf_offset_cal;

  localparam int NL = 2;
  localparam int ST = 4;
  localparam int SM = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NL-1:0] inbuf_o;
  logic [4*NL-1:0] osc;
  logic [NL-1:0] osc_en;
  logic          busy;
  logic          done;
  logic [NL-1:0] err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int off0 = 0;
  int off1 = 0;
  bit noisy0 = 0;
  bit noisy1 = 0;
  logic tog = 1'b0;

  logic [7:0] last_osc = 8'h88;

  typedef struct {
    logic [7:0] osc;
    logic [1:0] err;
    int         dlat;
    int         l1;
  } exp_t;

  exp_t sb[$];

  inbuf_offset_cal #(.NLANES(NL), .SETTLE(ST), .SAMPLES(SM)) dut (
    .clk(clk), .rst(rst), .start(start), .inbuf_o(inbuf_o),
    .osc(osc), .osc_en(osc_en), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
  end

  // Buffer model: O = (offset + 5*v > 0); at an exact zero a noisy buffer
  // toggles every cycle.
  function automatic logic buf_model(input logic [3:0] code, input int o,
                                     input bit nz, input logic t);
    int v;
    int val;
    v   = code[3] ? int'(code[2:0]) : -int'(code[2:0]);
    val = o + 5 * v;
    if (val > 0) return 1'b1;
    if (val == 0 && nz) return t;
    return 1'b0;
  endfunction

  assign inbuf_o[0] = osc_en[0] ? buf_model(osc[3:0], off0, noisy0, tog) : 1'b0;
  assign inbuf_o[1] = osc_en[1] ? buf_model(osc[7:4], off1, noisy1, tog) : 1'b0;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic int ktrip(input int o);
    for (int kk = 0; kk < 15; kk++)
      if (o + 5 * (kk - 7) > 0) return kk;
    return 15;
  endfunction

  function automatic logic [3:0] code_of(input int kk);
    int v;
    logic [2:0] m;
    v = kk - 7;
    if (v < 0) begin
      m = 3'(-v);
      return {1'b0, m};
    end
    m = 3'(v);
    return {1'b1, m};
  endfunction

  function automatic exp_t predict(input int o0, input int o1);
    exp_t e;
    int kt[2];
    int cl[2];
    logic [3:0] c[2];
    kt[0] = ktrip(o0);
    kt[1] = ktrip(o1);
    for (int i = 0; i < 2; i++) begin
      if (kt[i] == 15) begin
        c[i]  = 4'b1111;
        cl[i] = 15 * (ST + SM + 1) + 1;
      end else begin
        c[i]  = code_of(kt[i]);
        cl[i] = (kt[i] + 1) * (ST + SM + 1) + 1;
      end
    end
    e.osc  = {c[1], c[0]};
    e.err  = {(kt[1] == 0 || kt[1] == 15), (kt[0] == 0 || kt[0] == 15)};
    e.dlat = 1 + cl[0] + cl[1];
    e.l1   = cl[0] + 1;
    return e;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic launch(input int o0, input int o1, input bit n0, input bit n1,
                        input bit push, output int s);
    off0   = o0;
    off1   = o1;
    noisy0 = n0;
    noisy1 = n1;
    if (push) sb.push_back(predict(o0, o1));
    @(negedge clk);
    start = 1'b1;
    s = cyc;
  endtask

  task automatic run(input int s, input bit poke, output bit to, output int dl,
                     output int f1, output int ohv, output logic bd,
                     output logic b1, output logic [7:0] osc1,
                     output logic [1:0] err1);
    to = 1'b1; dl = -1; f1 = -1; ohv = 0;
    bd = 1'bx; b1 = 1'bx; osc1 = 'x; err1 = 'x;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == 0) begin
        b1   = busy;
        osc1 = osc;
        err1 = err;
      end
      if ($countones(osc_en) > 1) ohv++;
      if (f1 < 0 && osc_en[1]) f1 = cyc - s;
      if (done) begin
        dl = cyc - s;
        bd = busy;
        to = 1'b0;
        break;
      end
      start = poke && busy && (n % 23 == 5);
    end
    start = 1'b0;
  endtask

  // Full-run scenario with scoreboard pop and all end-of-run comparisons.
  task automatic scenario(input string nm, input int o0, input int o1,
                          input bit n0, input bit n1, input bit poke);
    int s, dl, f1, ohv;
    bit to;
    logic bd, b1;
    logic [7:0] osc1;
    logic [1:0] err1;
    exp_t e;
    logic [7:0] prev;
    prev = last_osc;
    launch(o0, o1, n0, n1, 1'b1, s);
    run(s, poke, to, dl, f1, ohv, bd, b1, osc1, err1);
    e = sb.pop_front();
    total++;
    if (to !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: done never seen within budget (expected at +%0d)", nm, e.dlat);
    end
    total++;
    if (dl !== e.dlat) begin
      bad++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", nm, dl, e.dlat);
    end
    total++;
    if (osc !== e.osc) begin
      bad++;
      $display("FAIL %s_osc: got %h expected %h", nm, osc, e.osc);
    end
    total++;
    if (err !== e.err) begin
      bad++;
      $display("FAIL %s_err: got %b expected %b", nm, err, e.err);
    end
    total++;
    if (bd !== 1'b0 || osc_en !== 2'b00) begin
      bad++;
      $display("FAIL %s_done_state: busy=%b osc_en=%b expected busy=0 osc_en=00", nm, bd, osc_en);
    end
    total++;
    if (b1 !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy_rise: busy at cycle 1 = %b expected 1", nm, b1);
    end
    total++;
    if (osc1 !== {prev[7:4], 4'b0111} || err1 !== 2'b00) begin
      bad++;
      $display("FAIL %s_first_apply: osc=%h err=%b expected osc=%h err=00",
               nm, osc1, err1, {prev[7:4], 4'b0111});
    end
    total++;
    if (f1 !== e.l1 || ohv !== 0) begin
      bad++;
      $display("FAIL %s_lane1_enable: first at +%0d (exp +%0d), onehot violations %0d (exp 0)",
               nm, f1, e.l1, ohv);
    end
    last_osc = e.osc;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (osc !== 8'h88 || osc_en !== 2'b00) begin
      bad++;
      $display("FAIL reset_osc: osc=%h osc_en=%b expected 88/00", osc, osc_en);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b expected 0/0/00", busy, done, err);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || osc !== 8'h88) begin
      bad++;
      $display("FAIL reset_idle: busy=%b osc=%h expected 0/88", busy, osc);
    end
  endtask

  task automatic test_basic();
    scenario("basic", 12, -12, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stuck();
    scenario("stuck", 40, -40, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    scenario("tie", 0, 12, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int s;
    int ndone;
    launch(12, -12, 1'b0, 1'b0, 1'b0, s);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100 && cyc < s + 50; n++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (osc !== 8'h88 || osc_en !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: osc=%h osc_en=%b busy=%b done=%b expected 88/00/0/0",
               osc, osc_en, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet: done pulses=%0d busy=%b expected 0/0", ndone, busy);
    end
    last_osc = 8'h88;
    scenario("after_reset", 12, -12, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    scenario("repeat_start", -12, 12, 1'b0, 1'b0, 1'b1);
    // start coinciding with done must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || osc_en !== 2'b00) begin
      bad++;
      $display("FAIL start_on_done: busy=%b osc_en=%b expected 0/00", busy, osc_en);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || osc !== last_osc) begin
      bad++;
      $display("FAIL start_on_done_idle: busy=%b done=%b osc=%h expected 0/0/%h",
               busy, done, osc, last_osc);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_basic();
    test_stuck();
    test_tie();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inbuf_offset_cal.md
# inbuf_offset_cal

Sequential offset-calibration controller for a bank of input buffers that expose a 4-bit offset trim (OSC) and an offset-calibration enable (OSC_EN). On `start`, the controller calibrates one lane at a time:
- it sweeps the trim code from most negative to most positive;
- it samples the buffer output for each code;
- it latches the first code at which the output resolves high.

It sits between the PHY bring-up sequencer and the per-bit input buffers. When it finishes, it leaves the calibrated trim codes applied and all buffers in normal (pad) mode.

## Interface
Parameters:
- `NLANES`, 8: number of buffers calibrated (1..32).
- `SETTLE`, 16: cycles each code is held before sampling. Covers the 2-flop synchronizer (>=3).
- `SAMPLES`, 16: cycles of output sampled per code (power of two, 2..256).

Ports:
- `clk` input 1: single clock. All state is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to run calibration. Ignored while `busy`=1.
- `inbuf_o` input NLANES: buffer outputs (O). Asynchronous to `clk`, so each bit goes through a 2-flop synchronizer.
- `osc` output 4*NLANES: trim code per lane. Lane i uses bits [4i+3:4i]. Bit 3 is the sign (1 = positive), bits 2:0 are the magnitude (5 units/step).
- `osc_en` output NLANES: calibration-mode enable per lane. At most one bit is high at a time.
- `busy` output 1: calibration in progress.
- `done` output 1: one-cycle pulse at the end of a run.
- `err` output NLANES: per-lane failure flag. Valid from `done` until the next `start`.

## Operation
- Code index k=0..14 maps to signed value v=k-7.
  - Encoding for v<0: {1'b0, |v|}. Example: k=0 → 4'b0111.
  - Encoding for v>=0: {1'b1, v}. Examples: k=7 → 4'b1000, k=14 → 4'b1111.
- FSM states: IDLE, APPLY, SAMPLE, DECIDE, NEXT, DONE.
- IDLE:
  - `start`=1 → lane=0, k=0, go to APPLY.
  - `busy` goes to 1 on the next cycle.
- APPLY:
  - Drives `osc_en[lane]`=1 and `osc[lane]`=enc(k). All other lanes keep their current code with `osc_en`=0.
  - Holds for SETTLE cycles, then goes to SAMPLE. The ones counter clears on entry.
- SAMPLE:
  - Holds for SAMPLES cycles.
  - Adds the synchronized `inbuf_o[lane]` to the ones counter each cycle. The counter is log2(SAMPLES)+1 bits wide.
  - Then goes to DECIDE.
- DECIDE (1 cycle): high = (ones > SAMPLES/2). An exact tie counts as low.
  - high and k=0 → err[lane]=1, code 4'b0111 kept (buffer stuck high) → NEXT.
  - high and k>0 → code enc(k) kept → NEXT.
  - low and k<14 → k=k+1 → APPLY.
  - low and k=14 → err[lane]=1, code 4'b1111 kept (stuck low) → NEXT.
- NEXT (1 cycle):
  - Clears `osc_en[lane]`.
  - lane<NLANES-1: lane+1, k=0 → APPLY.
  - Otherwise → DONE.
- DONE (1 cycle): `done`=1, `busy`=0 → IDLE.
- `err` clears on an accepted `start`. The `osc` registers of lanes not yet calibrated keep their previous values until their turn.
- Reset mid-run: all state and outputs return to their reset values immediately, and no `done` is produced.

## Timing
- Reset values:
  - `osc` = {NLANES{4'b1000}}.
  - `osc_en`, `busy`, `done`, `err` = 0.
  - FSM in IDLE, synchronizers 0.
- Output registering:
  - `osc` and `osc_en` change only at APPLY entry and NEXT; they are registered outputs.
  - `done` is registered. It is high for exactly one cycle, the same cycle `busy` falls.
- Per code: SETTLE+SAMPLES+1 cycles.
- Per lane: (ktrip+1)·(SETTLE+SAMPLES+1)+1 cycles, where ktrip = the final k (14 for stuck low).
- Run latency: `start` at cycle 0, `busy`=1 from cycle 1, `done` at cycle 1+Σ(per-lane cycles).
- Input synchronization: 2 cycles from pad to sample. SETTLE >= 3 guarantees no sample sees the previous code.
- `start` asserted in the same cycle as `done`: ignored (the FSM is not yet in IDLE).

## Test plan
Each lane uses a bench model O = (offset + 5v > 0) when `osc_en`=1.
- NLANES=1, SETTLE=4, SAMPLES=8, offset=+12 → ktrip=5, `osc`=4'b0010, `err`=0, `done` at cycle 1+6·13+1=80.
- NLANES=2, same parameters, offsets {+12, −12} → osc={4'b1011, 4'b0010}, err=2'b00, `done` at cycle 1+79+144=224. `osc_en` is one-hot, with lane 1 enabled only after lane 0's NEXT.
- Offsets +40 and −40 → codes 4'b0111 and 4'b1111, err=2'b11. Lane 0 finishes after 1 code; lane 1 after 15 codes.
- Tie/noise: model output toggles each cycle at v=0 (offset=0) → ones=4, counted low. Trip lands at k=8, code 4'b1001.
- Reset pulse at cycle 50 of a run → immediately `osc`=all 4'b1000, `osc_en`=0, `busy`=0, no `done`. A new `start` runs cleanly to completion.
- Repeated `start` pulses while `busy` → ignored, same results and `done` timing as a single start.
